// File: rtl/rr_priority_encoder_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
package encoder_pkg;

    // Grant FSM: IDLE looks for a request, HOLD presents it until accepted.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_t;

    // Increment an index and wrap back to 0 after width-1.
    // The wrap is at width-1, not at the next power of two.
    function automatic int unsigned idx_wrap(input int unsigned idx, input int unsigned width);
        return (idx >= width - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder_scan.sv
// Combinational round-robin scan: finds the first set request at or after ptr,
// wrapping at WIDTH-1, and returns its absolute index.
module priority_scan
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    input  logic [ADDR_SIZE-1:0] ptr,
    output logic                 found,
    output logic [ADDR_SIZE-1:0] idx
);

    logic [WIDTH-1:0]     w_rot;
    logic [ADDR_SIZE-1:0] w_off;
    logic [ADDR_SIZE:0]   w_sum;

    // Rotate req right by ptr so the requester at ptr lands on bit 0.
    // Index arithmetic is done modulo WIDTH, which need not be a power of 2.
    // The subtraction is taken modulo 2^ADDR_SIZE; the result is always
    // in 0..WIDTH-1, so the truncation is exact.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
        logic [ADDR_SIZE:0] w_j;
        assign w_j       = {1'b0, ptr} + (ADDR_SIZE+1)'(gi);
        assign w_rot[gi] = (w_j >= (ADDR_SIZE+1)'(WIDTH))
                         ? req[w_j[ADDR_SIZE-1:0] - ADDR_SIZE'(WIDTH)]
                         : req[w_j[ADDR_SIZE-1:0]];
    end

    // Find-first-set on the rotated vector (lowest bit wins).
    always_comb begin
        w_off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ADDR_SIZE'(i);
            end
        end
    end

    assign found = |w_rot;

    // Undo the rotation: absolute index = (ptr + offset) mod WIDTH.
    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= (ADDR_SIZE+1)'(WIDTH))
                 ? (w_sum[ADDR_SIZE-1:0] - ADDR_SIZE'(WIDTH))
                 : w_sum[ADDR_SIZE-1:0];

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered round-robin priority encoder with a valid/ready grant handshake
// and a one-hot ack back to the winning requester.
module rr_priority_encoder
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     req,
    output logic [ADDR_SIZE-1:0] out,
    output logic                 valid,
    input  logic                 ready,
    output logic [WIDTH-1:0]     ack
);

    enc_state_t           r_state;
    enc_state_t           w_state_next;
    logic [ADDR_SIZE-1:0] r_out;
    logic [ADDR_SIZE-1:0] w_out_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic [ADDR_SIZE-1:0] r_ptr;
    logic [ADDR_SIZE-1:0] w_ptr_next;

    logic                 w_found;
    logic [ADDR_SIZE-1:0] w_idx;
    logic                 w_hs;

    priority_scan #(
        .WIDTH     (WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_scan (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_hs = r_valid & ready;

    // State and grant registers; reset drops any held grant without acking it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_valid <= w_valid_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state: grab a grant in IDLE, hold it until the handshake, then
    // advance the pointer past the winner so it gets lowest priority next.
    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_valid_next = r_valid;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_valid_next = 1'b0;
                if (enable && w_found) begin
                    w_out_next   = w_idx;
                    w_valid_next = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_hs) begin
                    w_valid_next = 1'b0;
                    w_ptr_next   = ADDR_SIZE'(idx_wrap(32'(r_out), WIDTH));
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot ack of the held index, asserted only in the handshake cycle.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ack
        assign ack[gi] = w_hs & (r_out == ADDR_SIZE'(gi));
    end

    assign out   = r_out;
    assign valid = r_valid;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder at WIDTH=16 and WIDTH=5.
module tb_rr_priority_encoder;

    logic        clk;
    logic        reset;
    logic        en16;
    logic [15:0] req16;
    logic [3:0]  out16;
    logic        val16;
    logic        rdy16;
    logic [15:0] ack16;

    logic        rst5;
    logic        en5;
    logic [4:0]  req5;
    logic [2:0]  out5;
    logic        val5;
    logic        rdy5;
    logic [4:0]  ack5;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_on = 1'b0;

    rr_priority_encoder #(.WIDTH(16)) u16 (
        .clk    (clk),
        .reset  (reset),
        .enable (en16),
        .req    (req16),
        .out    (out16),
        .valid  (val16),
        .ready  (rdy16),
        .ack    (ack16)
    );

    rr_priority_encoder #(.WIDTH(5)) u5 (
        .clk    (clk),
        .reset  (rst5),
        .enable (en5),
        .req    (req5),
        .out    (out5),
        .valid  (val5),
        .ready  (rdy5),
        .ack    (ack5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: ack must be one-hot(out) gated by valid&ready; out5 in range.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [15:0] e16;
            logic [4:0]  e5;
            e16 = (val16 && rdy16) ? (16'd1 << out16) : 16'd0;
            e5  = (val5 && rdy5) ? (5'd1 << out5) : 5'd0;
            check_val("ack16_decode", 32'(ack16), 32'(e16));
            check_val("ack5_decode", 32'(ack5), 32'(e5));
            check_val("out5_range", 32'(out5 <= 3'd4), 32'd1);
            if (val16 && rdy16) $display("txn w16 grant out=%0d ack=%04h", out16, ack16);
            if (val5 && rdy5)   $display("txn w5  grant out=%0d ack=%02h", out5, ack5);
        end
    end

    initial begin
        reset = 1'b1; en16 = 1'b1; req16 = 16'hFFFF; rdy16 = 1'b0;
        rst5  = 1'b1; en5  = 1'b0; req5  = 5'b0;     rdy5  = 1'b0;

        // 1. reset held with all requests pending
        for (int i = 0; i < 4; i++) begin
            tick();
            mon_on = 1'b1;
            check_val("rst_valid", 32'(val16), 32'd0);
            check_val("rst_out", 32'(out16), 32'd0);
            check_val("rst_ack", 32'(ack16), 32'd0);
        end
        check_val("rst5_valid", 32'(val5), 32'd0);

        // 2. single request from ptr=0
        reset = 1'b0; rst5 = 1'b0;
        req16 = 16'h0010; rdy16 = 1'b1;
        tick();
        check_val("t2_valid", 32'(val16), 32'd1);
        check_val("t2_out", 32'(out16), 32'd4);
        check_val("t2_ack", 32'(ack16), 32'h0010);
        req16 = 16'h0000;
        tick();
        check_val("t2_drop", 32'(val16), 32'd0);

        // 3. ptr=5: bit 15 beats bit 0, then pointer wraps to 0
        req16 = 16'h8001;
        tick();
        check_val("t3_out15", 32'(out16), 32'd15);
        check_val("t3_ack15", 32'(ack16), 32'h8000);
        req16 = 16'h0001;
        tick();
        check_val("t3_bubble", 32'(val16), 32'd0);
        tick();
        check_val("t3_out0", 32'(out16), 32'd0);
        check_val("t3_valid0", 32'(val16), 32'd1);
        check_val("t3_ack0", 32'(ack16), 32'h0001);
        req16 = 16'h0000;
        tick();
        check_val("t3_drop", 32'(val16), 32'd0);

        // 4. grant out=3 held while ready=0 and req changes
        rdy16 = 1'b0; req16 = 16'h0008;
        tick();
        check_val("t4_out", 32'(out16), 32'd3);
        req16 = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t4_hold_out", 32'(out16), 32'd3);
            check_val("t4_hold_valid", 32'(val16), 32'd1);
            check_val("t4_hold_ack", 32'(ack16), 32'd0);
        end
        rdy16 = 1'b1; req16 = 16'h0000;
        #1;
        check_val("t4_ack", 32'(ack16), 32'h0008);
        tick();
        check_val("t4_drop", 32'(val16), 32'd0);

        // 5. enable=0 blocks new grants; ready with valid=0 ignored
        en16 = 1'b0; req16 = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("t5_noen", 32'(val16), 32'd0);
        end
        en16 = 1'b1;
        tick();
        check_val("t5_out", 32'(out16), 32'd4);
        check_val("t5_valid", 32'(val16), 32'd1);
        en16 = 1'b0; rdy16 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("t5_hold_valid", 32'(val16), 32'd1);
            check_val("t5_hold_out", 32'(out16), 32'd4);
        end
        rdy16 = 1'b1; req16 = 16'h0000;
        #1;
        check_val("t5_ack", 32'(ack16), 32'h0010);
        tick();
        check_val("t5_drop", 32'(val16), 32'd0);

        // 6. reset during a held grant clears valid/out/ptr
        en16 = 1'b1; req16 = 16'h0080; rdy16 = 1'b0;
        tick();
        check_val("t6_out7", 32'(out16), 32'd7);
        reset = 1'b1;
        tick();
        check_val("t6_rst_valid", 32'(val16), 32'd0);
        check_val("t6_rst_out", 32'(out16), 32'd0);
        reset = 1'b0; req16 = 16'hFFFF;
        tick();
        check_val("t6_ptr0_out", 32'(out16), 32'd0);
        check_val("t6_ptr0_valid", 32'(val16), 32'd1);
        rdy16 = 1'b1; req16 = 16'h0000;
        #1;
        check_val("t6_ack", 32'(ack16), 32'h0001);
        tick();

        // WIDTH=5: move ptr to 4, then check wrap at 4 -> 0
        en5 = 1'b1; req5 = 5'b01000; rdy5 = 1'b1;
        tick();
        check_val("w5_out3", 32'(out5), 32'd3);
        check_val("w5_ack3", 32'(ack5), 32'h08);
        req5 = 5'b00000;
        tick();
        check_val("w5_drop", 32'(val5), 32'd0);
        req5 = 5'b10001; rdy5 = 1'b0;
        tick();
        check_val("w5_out4", 32'(out5), 32'd4);
        check_val("w5_valid4", 32'(val5), 32'd1);
        rdy5 = 1'b1; req5 = 5'b00001;
        #1;
        check_val("w5_ack4", 32'(ack5), 32'h10);
        tick();
        check_val("w5_bubble", 32'(val5), 32'd0);
        tick();
        check_val("w5_out0", 32'(out5), 32'd0);
        check_val("w5_ack0", 32'(ack5), 32'h01);
        req5 = 5'b00000;
        tick();
        check_val("w5_end", 32'(val5), 32'd0);

        @(posedge clk);
        mon_on = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
